// File: rtl/display_scan_ctrl_if.sv
// Core-to-display bus: digit load/clear controls in, multiplexed display drive out.
interface display_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  localparam int CW = $clog2(NUM_DIGITS + 1);

  logic [3:0]            BCDIn;
  logic                  Load;
  logic                  Clear;
  logic [NUM_DIGITS-1:0] DigitSel;
  logic [6:0]            Segments;
  logic [CW-1:0]         DigitCount;
  logic                  Overflow;

  modport master (output BCDIn, Load, Clear,
                  input  DigitSel, Segments, DigitCount, Overflow);
  modport slave  (input  BCDIn, Load, Clear,
                  output DigitSel, Segments, DigitCount, Overflow);
endinterface

// File: rtl/display_scan_ctrl.sv
// Calculator-style digit store (shift in from the right) driving a multiplexed
// common-cathode 7-segment display through a prescaled one-hot scan.
module display_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 16
) (
  input logic                CLK,
  input logic                RESET_N,
  display_scan_ctrl_if.slave bus
);
  localparam int CW = $clog2(NUM_DIGITS + 1);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  function automatic logic [6:0] dec7(input logic [3:0] c);
    case (c)
      4'h0:    dec7 = 7'b0111111;
      4'h1:    dec7 = 7'b0000110;
      4'h2:    dec7 = 7'b1011011;
      4'h3:    dec7 = 7'b1001111;
      4'h4:    dec7 = 7'b1100110;
      4'h5:    dec7 = 7'b1101101;
      4'h6:    dec7 = 7'b1111101;
      4'h7:    dec7 = 7'b0000111;
      4'h8:    dec7 = 7'b1111111;
      4'h9:    dec7 = 7'b1101111;
      4'hA:    dec7 = 7'b1000000;
      default: dec7 = 7'b0000000;
    endcase
  endfunction

  logic [NUM_DIGITS-1:0][3:0] d;
  logic [CW-1:0]              cnt;
  logic                       ovf;

  // Digit store; Clear has priority over a coincident Load
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      d   <= '1;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (bus.Clear) begin
      d   <= '1;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (bus.Load) begin
      d <= {d[NUM_DIGITS-2:0], bus.BCDIn};
      if (cnt == CW'(NUM_DIGITS)) ovf <= 1'b1;
      else                        cnt <= cnt + 1'b1;
    end
  end

  // Scan FSM: prescaler + digit index
  logic [PW-1:0]         pre, pre_nxt;
  logic [IW-1:0]         idx, idx_nxt;
  logic [NUM_DIGITS-1:0] sel, sel_nxt;
  logic [6:0]            seg, seg_nxt;
  logic [3:0]            code;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pre <= '0;
      idx <= '0;
      sel <= NUM_DIGITS'(1);
      seg <= 7'b0111111;
    end else begin
      pre <= pre_nxt;
      idx <= idx_nxt;
      sel <= sel_nxt;
      seg <= seg_nxt;
    end
  end

  always_comb begin
    pre_nxt = pre + 1'b1;
    idx_nxt = idx;
    if (pre == PW'(SCAN_DIV - 1)) begin
      pre_nxt = '0;
      idx_nxt = (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
    end
  end

  // Outputs are computed for the index being entered so select and pattern
  // move together on the same edge.
  always_comb begin
    sel_nxt          = '0;
    sel_nxt[idx_nxt] = 1'b1;
    code             = d[idx_nxt];
    if (cnt == '0 && idx_nxt == '0) code = 4'h0;
    seg_nxt          = dec7(code);
  end

  assign bus.DigitSel   = sel;
  assign bus.Segments   = seg;
  assign bus.DigitCount = cnt;
  assign bus.Overflow   = ovf;
endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed plus random checks of display_scan_ctrl against a digit-list model.
module tb_display_scan_ctrl;
  localparam int ND = 4;
  localparam int SD = 4;

  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  always #5 CLK = ~CLK;

  display_scan_ctrl_if #(.NUM_DIGITS(ND)) ifc();
  display_scan_ctrl #(.NUM_DIGITS(ND), .SCAN_DIV(SD)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .bus(ifc.slave)
  );

  int total = 0;
  int bad   = 0;
  int k     = 0;        // clock edges since reset release
  int md[ND];           // model digits, md[0] rightmost
  int mcnt;
  int movf;

  function automatic logic [6:0] seg_of(input int c);
    case (c)
      0: return 7'b0111111;  1: return 7'b0000110;  2: return 7'b1011011;
      3: return 7'b1001111;  4: return 7'b1100110;  5: return 7'b1101101;
      6: return 7'b1111101;  7: return 7'b0000111;  8: return 7'b1111111;
      9: return 7'b1101111; 10: return 7'b1000000;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (k=%0d)", tag, obs, exp, k);
      $error("%s mismatch", tag);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < ND; i++) md[i] = 15;
    mcnt = 0;
    movf = 0;
  endtask

  // One clock: drive inputs, advance model, check all outputs after the edge.
  task automatic step(input logic ld, input logic clr, input logic [3:0] v);
    int snap[ND];
    int scnt, si, code;
    ifc.Load  = ld;
    ifc.Clear = clr;
    ifc.BCDIn = v;
    for (int i = 0; i < ND; i++) snap[i] = md[i];
    scnt = mcnt;
    @(posedge CLK);
    k++;
    if (clr) model_reset();
    else if (ld) begin
      if (mcnt == ND) movf = 1; else mcnt++;
      for (int i = ND - 1; i > 0; i--) md[i] = md[i-1];
      md[0] = int'(v);
    end
    #1;
    ifc.Load  = 1'b0;
    ifc.Clear = 1'b0;
    si   = (k / SD) % ND;
    code = (scnt == 0 && si == 0) ? 0 : snap[si];
    chk("digitsel",   32'(ifc.DigitSel),   32'(1 << si));
    chk("segments",   32'(ifc.Segments),   32'(seg_of(code)));
    chk("digitcount", 32'(ifc.DigitCount), 32'(mcnt));
    chk("overflow",   32'(ifc.Overflow),   32'(movf));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'h0);
  endtask

  initial begin
    logic found;
    ifc.Load = 1'b0; ifc.Clear = 1'b0; ifc.BCDIn = 4'h0;
    model_reset();
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RESET_N = 1'b1;
    #1;
    chk("rst_sel",  32'(ifc.DigitSel),   32'b0001);
    chk("rst_seg",  32'(ifc.Segments),   32'b0111111);
    chk("rst_cnt",  32'(ifc.DigitCount), 32'd0);
    chk("rst_ovf",  32'(ifc.Overflow),   32'd0);

    // empty display scan
    idle(4 * SD);

    // load 1,2,3 then watch a full scan
    step(1'b1, 1'b0, 4'd1); step(1'b1, 1'b0, 4'd2); step(1'b1, 1'b0, 4'd3);
    idle(ND * SD + 1);

    // overflow then clear
    step(1'b1, 1'b0, 4'd4); step(1'b1, 1'b0, 4'd5);
    idle(ND * SD);
    step(1'b0, 1'b1, 4'd0);
    idle(ND * SD);

    // load and clear together
    step(1'b1, 1'b0, 4'd8);
    step(1'b1, 1'b1, 4'd7);
    idle(ND * SD);

    // minus sign, digit, blank code
    step(1'b1, 1'b0, 4'hA); step(1'b1, 1'b0, 4'd5);
    idle(ND * SD);
    step(1'b1, 1'b0, 4'hC);
    idle(ND * SD);

    // random traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 2) == 0, $urandom_range(0, 24) == 0, 4'($urandom_range(0, 15)));

    // async reset while digit 2 selected, mid-dwell
    found = 1'b0;
    for (int i = 0; i < 2 * ND * SD && !found; i++) begin
      step(1'b1, 1'b0, 4'($urandom_range(0, 9)));
      if ((k / SD) % ND == 2 && k % SD == 1) found = 1'b1;
    end
    chk("find_idx2", 32'(found), 32'd1);
    chk("pre_rst_sel", 32'(ifc.DigitSel), 32'b0100);
    #1 RESET_N = 1'b0;
    #1;
    chk("arst_sel", 32'(ifc.DigitSel),   32'b0001);
    chk("arst_seg", 32'(ifc.Segments),   32'b0111111);
    chk("arst_cnt", 32'(ifc.DigitCount), 32'd0);
    chk("arst_ovf", 32'(ifc.Overflow),   32'd0);
    model_reset();
    k = 0;
    @(negedge CLK);
    RESET_N = 1'b1;
    idle(ND * SD);
    step(1'b1, 1'b0, 4'd9);
    idle(ND * SD);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
